// File: rtl/mul_booth_seq_if.sv
// Request/response bundle for the sequential Booth multiplier: operands and mode in,
// busy/done status and product out.
interface mul_booth_seq_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic                 is_signed;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, is_signed, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, is_signed, multiplicand, multiplier,
      output busy, done, product
   );
endinterface

// File: rtl/mul_booth_seq.sv
// Radix-4 Booth multiplier retiring two multiplier bits per clock, signed or unsigned.
// Optional build macro MUL_ZERO_SKIP_EN: zero operands complete straight from acceptance.
module mul_booth_seq #(
   parameter int WIDTH = 32
) (
   input logic            clock,
   input logic            reset_n,
   mul_booth_seq_if.slave bus
);
   localparam int EW = WIDTH + 2;
   localparam int AW = WIDTH + 3;
   localparam int SW = AW + EW + 1;
   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q;
   logic                  busy_q;
   logic                  done_q;
   logic [CW-1:0]         cnt_q;
   logic signed [AW-1:0]  acc_q;
   logic [EW-1:0]         a_q;
   logic [EW-1:0]         b_q;
   logic                  guard_q;
   logic [2*WIDTH-1:0]    product_q;

   logic signed [AW-1:0]  a_ext;
   logic signed [AW-1:0]  pp;
   logic signed [AW-1:0]  sum;
   logic signed [SW-1:0]  shifted_d;
   logic signed [AW-1:0]  acc_d;
   logic [EW-1:0]         b_d;
   logic                  guard_d;
   logic [2*WIDTH-1:0]    product_d;
   logic [EW-1:0]         a_in_d;
   logic [EW-1:0]         b_in_d;
   logic                  zero_d;
   logic                  accept;

   always_comb begin
      a_ext = {a_q[EW-1], a_q};
      pp    = '0;
      case ({b_q[1:0], guard_q})
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_ext <<< 1;
         3'b100:         pp = -(a_ext <<< 1);
         3'b101, 3'b110: pp = -a_ext;
         default:        pp = '0;
      endcase
      sum       = acc_q + pp;
      // Shift the whole {acc, B, guard} chain so the next Booth triplet lands in b_q[1:0]/guard.
      shifted_d = $signed({sum, b_q, guard_q}) >>> 2;
      acc_d     = shifted_d[SW-1 -: AW];
      b_d       = shifted_d[EW:1];
      guard_d   = shifted_d[0];
      product_d = shifted_d[2*WIDTH:1];

      a_in_d = {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
      b_in_d = {{2{bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};
`ifdef MUL_ZERO_SKIP_EN
      zero_d = (bus.multiplicand == '0) || (bus.multiplier == '0);
`else
      zero_d = 1'b0;
`endif
      accept = bus.start && (state_q != RUN);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               if (accept) begin
                  acc_q   <= '0;
                  a_q     <= a_in_d;
                  b_q     <= b_in_d;
                  guard_q <= 1'b0;
                  cnt_q   <= CW'(N);
                  if (zero_d) begin
                     state_q   <= DONE;
                     done_q    <= 1'b1;
                     product_q <= '0;
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               acc_q   <= acc_d;
               b_q     <= b_d;
               guard_q <= guard_d;
               cnt_q   <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  product_q <= product_d;
                  state_q   <= DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_mul_booth_seq.sv
// Scoreboard bench for mul_booth_seq (WIDTH=32): stimulus pushes expected product and
// completion edge, a monitor pops and compares on every done pulse.
module tb_mul_booth_seq;
   logic clock;
   logic reset_n;

   mul_booth_seq_if #(.WIDTH(32)) bus ();

   mul_booth_seq #(.WIDTH(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

`ifdef MUL_ZERO_SKIP_EN
   localparam int ZLAT = 0;
`else
   localparam int ZLAT = 17;
`endif

   typedef struct {
      logic [63:0] prod;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] p;
      int          lat;
   } vec_t;

   exp_t sb[$];
   int   edge_cnt = 0;
   int   npass = 0;
   int   ntotal = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (reset_n && bus.done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 64'(bus.done), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("product", bus.product, e.prod);
            chk("latency", 64'(edge_cnt), 64'(e.cyc));
            chk("busy_with_done", 64'(bus.busy), 64'd0);
         end
      end
   end

   // Called just after a falling edge; returns just after the falling edge following acceptance.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic push, input logic [63:0] p, input int lat);
      int k;
      bus.start        = 1'b1;
      bus.is_signed    = s;
      bus.multiplicand = a;
      bus.multiplier   = b;
      @(posedge clock);
      k = edge_cnt + 1;
      if (push) sb.push_back('{p, k + lat});
      @(negedge clock);
      bus.start = 1'b0;
      chk("busy_after_accept", 64'(bus.busy), (lat == 0) ? 64'd0 : 64'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!bus.done && n < 60) begin
         @(negedge clock);
         n++;
      end
      if (!bus.done) chk("done_timeout", 64'(bus.done), 64'd1);
   endtask

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{32'd16,         32'd10,         1'b1, 64'd160,                 17};
      vecs[1]  = '{32'hFFFFFFFD,   32'd7,          1'b1, 64'hFFFFFFFFFFFFFFEB,    17};
      vecs[2]  = '{32'h80000000,   32'h80000000,   1'b1, 64'h4000000000000000,    17};
      vecs[3]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE00000001,    17};
      vecs[4]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 64'h0000000000000001,    17};
      vecs[5]  = '{32'hFFFFFFFF,   32'd2,          1'b0, 64'h00000001FFFFFFFE,    17};
      vecs[6]  = '{32'h7FFFFFFF,   32'hFFFFFFFF,   1'b1, 64'hFFFFFFFF80000001,    17};
      vecs[7]  = '{32'h80000000,   32'h7FFFFFFF,   1'b1, 64'hC000000080000000,    17};
      vecs[8]  = '{32'h80000000,   32'h80000000,   1'b0, 64'h4000000000000000,    17};
      vecs[9]  = '{32'd0,          32'd1234,       1'b1, 64'd0,                   ZLAT};
      vecs[10] = '{32'd1234,       32'd0,          1'b0, 64'd0,                   ZLAT};

      reset_n          = 1'b0;
      bus.start        = 1'b0;
      bus.is_signed    = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      repeat (3) @(negedge clock);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_product", bus.product, 64'd0);
      reset_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, vecs[i].p, vecs[i].lat);
         wait_done();
         @(negedge clock);
         chk("done_one_cycle", 64'(bus.done), 64'd0);
      end

      // Start while busy is ignored; start during the DONE cycle is accepted back-to-back.
      issue(32'd5, 32'd6, 1'b0, 1'b1, 64'd30, 17);
      repeat (4) @(negedge clock);
      bus.start        = 1'b1;
      bus.multiplicand = 32'd9;
      bus.multiplier   = 32'd9;
      @(negedge clock);
      bus.start = 1'b0;
      wait_done();
      issue(32'd9, 32'd9, 1'b0, 1'b1, 64'd81, 17);
      wait_done();
      @(negedge clock);

      // Reset mid-operation discards the in-flight multiply without a done pulse.
      issue(32'd100, 32'd100, 1'b1, 1'b0, 64'd0, 17);
      repeat (7) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_done", 64'(bus.done), 64'd0);
      chk("midrst_product", bus.product, 64'd0);
      repeat (25) @(negedge clock);
      chk("midrst_product_hold", bus.product, 64'd0);
      issue(32'd100, 32'd100, 1'b1, 1'b1, 64'd10000, 17);
      wait_done();
      @(negedge clock);
      chk("product_hold", bus.product, 64'd10000);

      repeat (3) @(negedge clock);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", npass, ntotal);
      $fatal(1, "watchdog");
   end
endmodule
